// File: rtl/vx_ti_short_stack.sv
// vx_ti_short_stack: multi-context bounded short stack for BVH traversal.
// Each context keeps a circular window of the newest STACK_SIZE node addresses.
// A push into a full context overwrites the oldest entry and latches an
// overflow flag. An empty pop on an overflowed context then reports "restart".
// Pop/swap results come out on a registered response port one cycle after
// the request is accepted.
// Optional feature macro: VX_TI_STACK_PERF_EN adds saturating perf counters.
module vx_ti_short_stack #(
   parameter int NUM_STACKS = 4,
   parameter int STACK_SIZE = 5,
   parameter int ENTRY_BITS = 32,
   parameter int SID_BITS   = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              req_op,
   input  logic [SID_BITS-1:0]     req_sid,
   input  logic [ENTRY_BITS-1:0]   req_data,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [SID_BITS-1:0]     rsp_sid,
   output logic [ENTRY_BITS-1:0]   rsp_data,
   output logic                    rsp_empty,
   output logic                    rsp_restart,
   output logic [NUM_STACKS-1:0]   stack_empty,
   output logic [NUM_STACKS-1:0]   stack_full
`ifdef VX_TI_STACK_PERF_EN
   ,
   output logic [31:0]                     perf_overflows,
   output logic [31:0]                     perf_restarts,
   output logic [$clog2(STACK_SIZE+1)-1:0] perf_max_depth
`endif
);

   localparam int PTR_W = $clog2(STACK_SIZE);
   localparam int CNT_W = $clog2(STACK_SIZE + 1);

   typedef enum logic [1:0] {
      OP_PUSH  = 2'd0,
      OP_POP   = 2'd1,
      OP_SWAP  = 2'd2,
      OP_CLEAR = 2'd3
   } op_e;

   // Per-context state and shared storage (storage is intentionally not reset).
   logic [PTR_W-1:0]      top [NUM_STACKS];
   logic [CNT_W-1:0]      cnt [NUM_STACKS];
   logic                  ovf [NUM_STACKS];
   logic [ENTRY_BITS-1:0] mem [NUM_STACKS][STACK_SIZE];

   op_e                   op;
   logic                  sid_ok;
   logic                  do_op;
   logic [PTR_W-1:0]      cur_top;
   logic [CNT_W-1:0]      cur_cnt;
   logic                  cur_ovf;
   logic [ENTRY_BITS-1:0] cur_entry;
   logic [PTR_W-1:0]      top_inc;
   logic [PTR_W-1:0]      top_dec;
   logic                  cur_full;

   logic [PTR_W-1:0]      nxt_top;
   logic [CNT_W-1:0]      nxt_cnt;
   logic                  nxt_ovf;
   logic                  wr_en;
   logic [PTR_W-1:0]      wr_ptr;
   logic                  ld_rsp;
   logic [ENTRY_BITS-1:0] ld_data;
   logic                  ld_empty;
   logic                  ld_restart;
   logic                  drop;

   assign op        = op_e'(req_op);
   assign req_ready = !rsp_valid || rsp_ready;
   assign sid_ok    = (32'(req_sid) < NUM_STACKS);
   assign do_op     = req_valid && req_ready && sid_ok;

   // Selected context view and modular pointer neighbours.
   always_comb begin
      cur_top   = '0;
      cur_cnt   = '0;
      cur_ovf   = 1'b0;
      cur_entry = '0;
      if (sid_ok) begin
         cur_top   = top[req_sid];
         cur_cnt   = cnt[req_sid];
         cur_ovf   = ovf[req_sid];
         cur_entry = mem[req_sid][cur_top];
      end
      top_inc  = (cur_top == PTR_W'(STACK_SIZE - 1)) ? '0 : cur_top + 1'b1;
      top_dec  = (cur_top == '0) ? PTR_W'(STACK_SIZE - 1) : cur_top - 1'b1;
      cur_full = (cur_cnt == CNT_W'(STACK_SIZE));
   end

   // Next-state for the addressed context, storage write and response load.
   always_comb begin
      nxt_top    = cur_top;
      nxt_cnt    = cur_cnt;
      nxt_ovf    = cur_ovf;
      wr_en      = 1'b0;
      wr_ptr     = cur_top;
      ld_rsp     = 1'b0;
      ld_data    = '0;
      ld_empty   = 1'b0;
      ld_restart = 1'b0;
      drop       = 1'b0;
      unique case (op)
         OP_PUSH: begin
            nxt_top = top_inc;
            wr_en   = 1'b1;
            wr_ptr  = top_inc;
            if (cur_full) begin
               nxt_ovf = 1'b1;
               drop    = 1'b1;
            end else begin
               nxt_cnt = cur_cnt + 1'b1;
            end
         end
         OP_POP: begin
            ld_rsp = 1'b1;
            if (cur_cnt != '0) begin
               ld_data = cur_entry;
               nxt_top = top_dec;
               nxt_cnt = cur_cnt - 1'b1;
            end else begin
               ld_empty   = 1'b1;
               ld_restart = cur_ovf;
               nxt_ovf    = 1'b0;
            end
         end
         OP_SWAP: begin
            ld_rsp = 1'b1;
            wr_en  = 1'b1;
            if (cur_cnt != '0) begin
               ld_data = cur_entry;
            end else begin
               // Empty swap: behaves as an empty pop followed by a push.
               ld_empty   = 1'b1;
               ld_restart = cur_ovf;
               nxt_ovf    = 1'b0;
               nxt_top    = top_inc;
               wr_ptr     = top_inc;
               nxt_cnt    = CNT_W'(1);
            end
         end
         OP_CLEAR: begin
            nxt_top = '0;
            nxt_cnt = '0;
            nxt_ovf = 1'b0;
         end
         default: ;
      endcase
   end

   // Context state registers, updated in the acceptance cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_STACKS; i++) begin
            top[i] <= '0;
            cnt[i] <= '0;
            ovf[i] <= 1'b0;
         end
      end else if (do_op) begin
         top[req_sid] <= nxt_top;
         cnt[req_sid] <= nxt_cnt;
         ovf[req_sid] <= nxt_ovf;
      end
   end

   // Entry storage; reads are combinational so a following op sees new data.
   always_ff @(posedge clk) begin
      if (do_op && wr_en) begin
         mem[req_sid][wr_ptr] <= req_data;
      end
   end

   // Registered response, held while the consumer stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid   <= 1'b0;
         rsp_sid     <= '0;
         rsp_data    <= '0;
         rsp_empty   <= 1'b0;
         rsp_restart <= 1'b0;
      end else if (do_op && ld_rsp) begin
         rsp_valid   <= 1'b1;
         rsp_sid     <= req_sid;
         rsp_data    <= ld_data;
         rsp_empty   <= ld_empty;
         rsp_restart <= ld_restart;
      end else if (rsp_ready) begin
         rsp_valid   <= 1'b0;
      end
   end

   // Per-context status flags from registered counts.
   always_comb begin
      for (int unsigned i = 0; i < NUM_STACKS; i++) begin
         stack_empty[i] = (cnt[i] == '0);
         stack_full[i]  = (cnt[i] == CNT_W'(STACK_SIZE));
      end
   end

`ifdef VX_TI_STACK_PERF_EN
   // Saturating performance counters and peak depth tracker.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_overflows <= '0;
         perf_restarts  <= '0;
         perf_max_depth <= '0;
      end else if (do_op) begin
         if (drop && (perf_overflows != '1)) begin
            perf_overflows <= perf_overflows + 1'b1;
         end
         if (ld_rsp && ld_restart && (perf_restarts != '1)) begin
            perf_restarts <= perf_restarts + 1'b1;
         end
         if (nxt_cnt > perf_max_depth) begin
            perf_max_depth <= nxt_cnt;
         end
      end
   end
`endif

endmodule
